// File: rtl/fib_pkg.sv
// Shared types and default sizing for the Fibonacci sequence generator.
package fib_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fib_state_e;

  localparam int FIB_WIDTH_DEF = 16;
  localparam int FIB_IDX_W_DEF = 8;

endpackage : fib_pkg

// File: rtl/fib_add.sv
// WIDTH-bit ripple-carry adder producing the next Fibonacci term and its carry-out.
module fib_add
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule : fib_add

// File: rtl/fib_seq_gen.sv
// Fibonacci term generator: A/B term pair advanced on en, seedable by load,
// either halting or wrapping when the next sum no longer fits in WIDTH bits.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF,
  parameter int IDX_W = FIB_IDX_W_DEF,
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  output logic [WIDTH-1:0] out,
  output logic [IDX_W-1:0] idx,
  output logic             ovf,
  output logic             done
);

  localparam bit WRAP_EN = (WRAP != 0);

  fib_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [IDX_W-1:0] idx_inc;

  fib_add #(.WIDTH(WIDTH)) u_add (
    .a    (a_q),
    .b    (b_q),
    .sum  (sum),
    .cout (carry)
  );

  // The advance counter saturates instead of rolling over.
  assign idx_inc = (idx_q == {IDX_W{1'b1}}) ? idx_q : idx_q + IDX_W'(1);

  // NOTE: every always_comb target is given its hold value first, so no path
  // through the branches below can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;

    if (load) begin
      a_d     = seed0;
      b_d     = seed1;
      idx_d   = '0;
      ovf_d   = 1'b0;
      state_d = RUN;
    end else if (en && (state_q == RUN)) begin
      a_d   = b_q;
      idx_d = idx_inc;
      if (!carry) begin
        b_d = sum;
      end else if (WRAP_EN) begin
        b_d   = sum;
        ovf_d = 1'b1;
      end else begin
        // B keeps the last representable term so A lands on it and stays.
        state_d = HALT;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      a_q     <= '0;
      b_q     <= WIDTH'(1);
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out  = a_q;
  assign idx  = idx_q;
  assign ovf  = ovf_q;
  assign done = (state_q == HALT);

endmodule : fib_seq_gen

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench: three generators (halt, wrap, narrow idx) share stimulus;
// directed steps queue hand-computed expectations, a negedge monitor checks them.
module tb_fib_seq_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] seed0 = '0;
  logic [15:0] seed1 = '0;

  logic [15:0] out0, out1, out2;
  logic [7:0]  idx0, idx1;
  logic [2:0]  idx2;
  logic        ovf0, ovf1, ovf2;
  logic        done0, done1, done2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int d;
    int tag;
    int out;
    int idx;
    bit ovf;
    bit done;
  } exp_t;

  exp_t sb[$];
  int   step_no = 0;

  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(16), .IDX_W(8), .WRAP(0)) u_halt (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed0(seed0), .seed1(seed1),
    .out(out0), .idx(idx0), .ovf(ovf0), .done(done0)
  );

  fib_seq_gen #(.WIDTH(16), .IDX_W(8), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed0(seed0), .seed1(seed1),
    .out(out1), .idx(idx1), .ovf(ovf1), .done(done1)
  );

  fib_seq_gen #(.WIDTH(16), .IDX_W(3), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed0(seed0), .seed1(seed1),
    .out(out2), .idx(idx2), .ovf(ovf2), .done(done2)
  );

  // Monitor: outputs are registered, so every queued expectation is compared
  // at the falling edge following the edge that produced it.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      int   a_out, a_idx;
      bit   a_ovf, a_done;
      e = sb.pop_front();
      case (e.d)
        0:       begin a_out = int'(out0); a_idx = int'(idx0); a_ovf = ovf0; a_done = done0; end
        1:       begin a_out = int'(out1); a_idx = int'(idx1); a_ovf = ovf1; a_done = done1; end
        default: begin a_out = int'(out2); a_idx = int'(idx2); a_ovf = ovf2; a_done = done2; end
      endcase
      n_checks++;
      if (a_out != e.out || a_idx != e.idx || a_ovf != e.ovf || a_done != e.done) begin
        n_fail++;
        $display("FAIL step%0d dut%0d: got out=%0d idx=%0d ovf=%0b done=%0b, want out=%0d idx=%0d ovf=%0b done=%0b",
                 e.tag, e.d, a_out, a_idx, a_ovf, a_done, e.out, e.idx, e.ovf, e.done);
      end
    end
  end

  task automatic cycle(input bit r, input bit l, input bit e,
                       input logic [15:0] s0 = '0, input logic [15:0] s1 = '0);
    rst   = r;
    load  = l;
    en    = e;
    seed0 = s0;
    seed1 = s1;
    @(posedge clk);
    #1;
    step_no++;
  endtask

  task automatic push(input int d, input int o, input int i, input bit v, input bit dn);
    exp_t e;
    e.d = d; e.tag = step_no; e.out = o; e.idx = i; e.ovf = v; e.done = dn;
    sb.push_back(e);
  endtask

  // Same expectation on all three generators; the 3-bit counter saturates at 7.
  task automatic push_all(input int o, input int i);
    push(0, o, i, 1'b0, 1'b0);
    push(1, o, i, 1'b0, 1'b0);
    push(2, o, (i > 7) ? 7 : i, 1'b0, 1'b0);
  endtask

  initial begin
    int fib[8];
    int lucas[6];
    fib   = '{0, 1, 1, 2, 3, 5, 8, 13};
    lucas = '{2, 1, 3, 4, 7, 11};

    @(posedge clk);
    #1;

    // Reset state, then the opening Fibonacci terms.
    cycle(1, 0, 0);
    push_all(0, 0);
    for (int i = 1; i < 8; i++) begin
      cycle(0, 0, 1);
      push_all(fib[i], i);
    end

    // Advances 8..22 unchecked, then the overflow boundary at 23/24.
    repeat (15) cycle(0, 0, 1);
    cycle(0, 0, 1);
    push_all(28657, 23);
    cycle(0, 0, 1);
    push(0, 46368, 24, 1'b0, 1'b1);
    push(1, 46368, 24, 1'b1, 1'b0);
    push(2, 46368, 7,  1'b0, 1'b1);

    // Halted build ignores en; wrapping build shows the wrapped term.
    cycle(0, 0, 1);
    push(0, 46368, 24, 1'b0, 1'b1);
    push(1, 9489,  25, 1'b1, 1'b0);
    push(2, 46368, 7,  1'b0, 1'b1);

    // rst beats load and en, also out of HALT and with ovf set.
    cycle(1, 1, 1, 16'd2, 16'd1);
    push_all(0, 0);
    cycle(0, 0, 1);
    push_all(1, 1);

    // Back to HALT, then hold with en low.
    repeat (22) cycle(0, 0, 1);
    cycle(0, 0, 1);
    push(0, 46368, 24, 1'b0, 1'b1);
    push(1, 46368, 24, 1'b1, 1'b0);
    push(2, 46368, 7,  1'b0, 1'b1);
    cycle(0, 0, 0);
    push(0, 46368, 24, 1'b0, 1'b1);
    push(1, 46368, 24, 1'b1, 1'b0);
    push(2, 46368, 7,  1'b0, 1'b1);

    // load with en in HALT: seeds only, RUN again, ovf cleared; Lucas run.
    cycle(0, 1, 1, 16'd2, 16'd1);
    push_all(lucas[0], 0);
    for (int i = 1; i < 6; i++) begin
      cycle(0, 0, 1);
      push_all(lucas[i], i);
    end

    // en toggled every cycle.
    cycle(0, 0, 0); push_all(11, 5);
    cycle(0, 0, 1); push_all(18, 6);
    cycle(0, 0, 0); push_all(18, 6);
    cycle(0, 0, 1); push_all(29, 7);

    // rst pulse mid-run, then first advance after release.
    cycle(1, 0, 1);
    push_all(0, 0);
    cycle(0, 0, 1);
    push_all(1, 1);

    cycle(0, 0, 0);
    push_all(1, 1);

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fib_seq_gen
